prog_timer: RTL and testbench

//  Parametrised, prescaled up/down timer: the next generation of the reaction-game timer.

---
 rtl/prog_timer_pkg.sv | 19 +
 rtl/prog_timer_tick.sv | 39 +++
 rtl/prog_timer.sv | 111 +++++++++++
 tb/tb_prog_timer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_timer_pkg.sv
// Shared types and constants for the prescaled up/down timer.
package prog_timer_pkg;

    // End-of-range behaviour; 2'b11 is reserved and decodes as saturate.
    typedef enum logic [1:0] {
        MODE_WRAP    = 2'b00,
        MODE_SAT     = 2'b01,
        MODE_REVERSE = 2'b10
    } mode_t;

    localparam int unsigned CLK_HZ   = 50_000_000;
    localparam int unsigned TICK_1MS = 50_000;

    // Prescaler register width: enough for 0..clks-1, never narrower than one bit.
    function automatic int unsigned prescaler_width(input int unsigned clks);
        return (clks > 1) ? $clog2(clks) : 1;
    endfunction

endpackage

// File: rtl/prog_timer_tick.sv
// Prescaler: produces one tick per CLKS_PER_TICK enabled clock cycles.
module tick_gen
    import prog_timer_pkg::*;
#(
    parameter int unsigned CLKS_PER_TICK = TICK_1MS
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int unsigned PW = prescaler_width(CLKS_PER_TICK);
    localparam logic [PW-1:0] LastCnt = PW'(CLKS_PER_TICK - 1);

    logic [PW-1:0] cnt_q, cnt_d;

    // Tick is combinational so the count step lands on the edge that ends this cycle.
    always_comb begin
        tick  = enable && (cnt_q == LastCnt);
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = tick ? '0 : cnt_q + PW'(1);
        end
    end

    // Prescaler register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/prog_timer.sv
// Prescaled up/down timer with wrap, saturate and auto-reverse end-of-range handling.
module prog_timer
    import prog_timer_pkg::*;
#(
    parameter int unsigned WIDTH         = 11,
    parameter int unsigned CLKS_PER_TICK = TICK_1MS
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] start_value,
    input  logic             up,
    input  logic             enable,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] timer_value,
    output logic             counting_up,
    output logic             tick,
    output logic             zero,
    output logic             overflow
);

    localparam logic [WIDTH-1:0] MaxVal = '1;
    localparam logic [WIDTH-1:0] One    = WIDTH'(1);

    logic [WIDTH-1:0] value_q, value_d;
    logic             dir_q, dir_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    // Load also clears the prescaler so the first step is a full period away.
    tick_gen #(
        .CLKS_PER_TICK(CLKS_PER_TICK)
    ) u_tick_gen (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (load),
        .enable (enable),
        .tick   (tick)
    );

    // Next-state: load beats tick; a tick coincident with load is dropped.
    always_comb begin
        value_d = value_q;
        dir_d   = dir_q;
        ovf_d   = ovf_q;
        if (load) begin
            value_d = start_value;
            dir_d   = up;
            ovf_d   = 1'b0;
        end else if (tick) begin
            if (dir_q) begin
                if (value_q != MaxVal) begin
                    value_d = value_q + One;
                end else begin
                    ovf_d = 1'b1;
                    case (mode)
                        MODE_WRAP: value_d = '0;
                        MODE_REVERSE: begin
                            dir_d   = 1'b0;
                            value_d = MaxVal - One;
                        end
                        default: value_d = MaxVal;
                    endcase
                end
            end else begin
                if (value_q != '0) begin
                    value_d = value_q - One;
                end else begin
                    case (mode)
                        MODE_WRAP: begin
                            value_d = MaxVal;
                            ovf_d   = 1'b1;
                        end
                        // Bouncing off zero is the normal reaction-game turnaround, not an error.
                        MODE_REVERSE: begin
                            dir_d   = 1'b1;
                            value_d = One;
                        end
                        default: begin
                            value_d = '0;
                            ovf_d   = 1'b1;
                        end
                    endcase
                end
            end
        end
        // Pulse only on a transition into zero, whatever caused it.
        zero_d = (value_d == '0) && (value_q != '0);
    end

    // Count, direction and flag registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            value_q <= '0;
            dir_q   <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            value_q <= value_d;
            dir_q   <= dir_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign timer_value = value_q;
    assign counting_up = dir_q;
    assign zero        = zero_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_prog_timer.sv
// Self-checking bench for prog_timer: vector table, directed sequences, random vs model.
module tb_prog_timer;

    localparam int W   = 11;
    localparam int K   = 2;
    localparam int MAX = 2047;

    logic          clk = 1'b0;
    logic          reset_n, load, up, enable;
    logic [W-1:0]  start_value;
    logic [1:0]    mode;
    logic [W-1:0]  timer_value;
    logic          counting_up, tick, zero, overflow;

    logic          b_reset_n, b_load, b_up, b_enable;
    logic [W-1:0]  b_start_value;
    logic [1:0]    b_mode;
    logic [W-1:0]  b_timer_value;
    logic          b_counting_up, b_tick, b_zero, b_overflow;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int m_val, m_pre;
    bit m_dir, m_ovf, m_zero, m_tick;

    always #5 clk = ~clk;

    prog_timer #(.WIDTH(W), .CLKS_PER_TICK(K)) dut (
        .clk(clk), .reset_n(reset_n), .load(load), .start_value(start_value), .up(up),
        .enable(enable), .mode(mode), .timer_value(timer_value), .counting_up(counting_up),
        .tick(tick), .zero(zero), .overflow(overflow)
    );

    prog_timer #(.WIDTH(W), .CLKS_PER_TICK(1)) dut1 (
        .clk(clk), .reset_n(b_reset_n), .load(b_load), .start_value(b_start_value), .up(b_up),
        .enable(b_enable), .mode(b_mode), .timer_value(b_timer_value),
        .counting_up(b_counting_up), .tick(b_tick), .zero(b_zero), .overflow(b_overflow)
    );

    typedef struct {
        logic rn, ld;
        int   sv;
        logic u, en;
        int   md;
        int   ev;
        logic ed, ez, eo;
    } vec_t;

    function automatic vec_t mk(logic rn, logic ld, int sv, logic u, logic en, int md,
                                int ev, logic ed, logic ez, logic eo);
        vec_t v;
        v.rn = rn; v.ld = ld; v.sv = sv; v.u = u; v.en = en; v.md = md;
        v.ev = ev; v.ed = ed; v.ez = ez; v.eo = eo;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Apply one count step following the end-of-range rules, using plain integers.
    task automatic model_step(input int md);
        int delta;
        delta = m_dir ? 1 : -1;
        if (m_val + delta >= 0 && m_val + delta <= MAX) begin
            m_val = m_val + delta;
        end else if (md == 0) begin
            m_val = (m_val + delta + MAX + 1) % (MAX + 1);
            m_ovf = 1;
        end else if (md == 2) begin
            m_dir = !m_dir;
            m_val = m_val - delta;
            if (m_dir == 0) m_ovf = 1; // only the top turnaround counts as overflow
        end else begin
            m_ovf = 1;
        end
    endtask

    task automatic model_edge(input logic r, input logic l, input int sv, input logic u,
                              input logic e, input int md, input bit t);
        int old;
        old = m_val;
        if (!r) begin
            m_val = 0; m_dir = 0; m_ovf = 0; m_pre = 0; m_zero = 0;
        end else if (l) begin
            m_val = sv; m_dir = u; m_ovf = 0; m_pre = 0;
            m_zero = (m_val == 0) && (old != 0);
        end else begin
            if (e) m_pre = t ? 0 : m_pre + 1;
            if (t) model_step(md);
            m_zero = (m_val == 0) && (old != 0);
        end
    endtask

    // One clock of the main DUT, compared against the model every cycle.
    task automatic cyc(input logic r, input logic l, input int sv, input logic u,
                       input logic e, input int md);
        reset_n = r; load = l; start_value = W'(sv); up = u; enable = e; mode = 2'(md);
        #1;
        m_tick = e && (m_pre == K - 1);
        check("model_tick", 32'(tick), 32'(m_tick));
        @(posedge clk);
        model_edge(r, l, sv, u, e, md, m_tick);
        #1;
        check("model_value", 32'(timer_value), 32'(m_val));
        check("model_dir", 32'(counting_up), 32'(m_dir));
        check("model_zero", 32'(zero), 32'(m_zero));
        check("model_ovf", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic bcyc(input logic r, input logic l, input int sv, input logic u,
                        input logic e, input int md);
        b_reset_n = r; b_load = l; b_start_value = W'(sv); b_up = u; b_enable = e;
        b_mode = 2'(md);
        #1;
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[$];

    initial begin
        int zc;
        reset_n = 0; load = 0; start_value = '0; up = 0; enable = 0; mode = '0;
        b_reset_n = 0; b_load = 0; b_start_value = '0; b_up = 0; b_enable = 0; b_mode = '0;
        m_val = 0; m_pre = 0; m_dir = 0; m_ovf = 0; m_zero = 0; m_tick = 0;

        // Hand-computed vectors (CLKS_PER_TICK=2): reset, WRAP at MAX, load during a tick.
        tbl.push_back(mk(0, 0, 0,    0, 0, 0, 0,    0, 0, 0));
        tbl.push_back(mk(0, 1, 9,    1, 1, 0, 0,    0, 0, 0));
        tbl.push_back(mk(1, 1, 2046, 1, 1, 0, 2046, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0,    0, 1, 0, 2046, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0,    0, 1, 0, 2047, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0,    0, 1, 0, 2047, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0,    0, 1, 0, 0,    1, 1, 1));
        tbl.push_back(mk(1, 0, 0,    0, 1, 0, 0,    1, 0, 1));
        tbl.push_back(mk(1, 1, 5,    0, 1, 1, 5,    0, 0, 0));
        tbl.push_back(mk(1, 0, 0,    0, 1, 1, 5,    0, 0, 0));
        tbl.push_back(mk(1, 0, 0,    0, 1, 1, 4,    0, 0, 0));
        tbl.push_back(mk(1, 0, 0,    0, 0, 1, 4,    0, 0, 0));
        tbl.push_back(mk(1, 0, 0,    0, 0, 1, 4,    0, 0, 0));
        tbl.push_back(mk(1, 0, 0,    0, 1, 1, 4,    0, 0, 0));
        tbl.push_back(mk(1, 0, 0,    0, 1, 1, 3,    0, 0, 0));
        tbl.push_back(mk(1, 1, 0,    0, 0, 1, 0,    0, 1, 0));
        tbl.push_back(mk(1, 0, 0,    0, 0, 1, 0,    0, 0, 0));
        foreach (tbl[i]) begin
            cyc(tbl[i].rn, tbl[i].ld, tbl[i].sv, tbl[i].u, tbl[i].en, tbl[i].md);
            check($sformatf("vec%0d_value", i), 32'(timer_value), 32'(tbl[i].ev));
            check($sformatf("vec%0d_dir", i), 32'(counting_up), 32'(tbl[i].ed));
            check($sformatf("vec%0d_zero", i), 32'(zero), 32'(tbl[i].ez));
            check($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(tbl[i].eo));
        end

        // Reset hold mid-count, with load asserted to show reset wins.
        cyc(1, 1, 500, 1, 1, 0);
        for (int c = 0; c < 5; c++) cyc(1, 0, 0, 0, 1, 0);
        cyc(0, 1, 77, 1, 1, 0);
        check("rst_value", 32'(timer_value), 32'd0);
        check("rst_dir", 32'(counting_up), 32'd0);
        check("rst_flags", {30'd0, zero, overflow}, 32'd0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 1, 0);
        check("rst_restart_c1", 32'(timer_value), 32'd0);
        cyc(1, 0, 0, 0, 1, 0);
        check("rst_restart_c2", 32'(timer_value), 32'(MAX));
        check("rst_restart_ovf", 32'(overflow), 32'd1);

        // Auto-reverse: 10 down to 0, then back up to 10 by cycle 40.
        cyc(1, 1, 10, 0, 1, 2);
        zc = 0;
        for (int c = 1; c <= 40; c++) begin
            cyc(1, 0, 0, 0, 1, 2);
            zc += int'(zero);
            if (c == 20) begin
                check("rev_c20_value", 32'(timer_value), 32'd0);
                check("rev_c20_zero", 32'(zero), 32'd1);
            end
        end
        check("rev_zero_count", 32'(zc), 32'd1);
        check("rev_c40_value", 32'(timer_value), 32'd10);
        check("rev_c40_dir", 32'(counting_up), 32'd1);
        check("rev_c40_ovf", 32'(overflow), 32'd0);

        // Saturate at 0: single zero pulse, then held for 10 ticks.
        cyc(1, 1, 1, 0, 1, 1);
        zc = 0;
        for (int c = 1; c <= 22; c++) begin
            cyc(1, 0, 0, 0, 1, 1);
            zc += int'(zero);
        end
        check("sat_value", 32'(timer_value), 32'd0);
        check("sat_zero_count", 32'(zc), 32'd1);
        check("sat_ovf", 32'(overflow), 32'd1);

        // Freeze for 7 cycles mid-period; resume finishes the held phase.
        cyc(1, 1, 100, 1, 1, 0);
        for (int c = 0; c < 3; c++) cyc(1, 0, 0, 0, 1, 0);
        for (int c = 0; c < 7; c++) begin
            cyc(1, 0, 0, 0, 0, 0);
            check("frz_value", 32'(timer_value), 32'd101);
        end
        cyc(1, 0, 0, 0, 1, 0);
        check("frz_resume", 32'(timer_value), 32'd102);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            int sv, sel;
            sel = int'($urandom_range(0, 3));
            case (sel)
                0: sv = int'($urandom_range(0, 2));
                1: sv = int'($urandom_range(MAX - 2, MAX));
                default: sv = int'($urandom_range(0, MAX));
            endcase
            cyc(($urandom_range(0, 49) != 0), ($urandom_range(0, 19) == 0), sv,
                1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 8),
                int'($urandom_range(0, 3)));
        end

        // CLKS_PER_TICK=1 instance: tick every enabled cycle, load of 0 pulses zero.
        bcyc(0, 0, 0, 0, 0, 1);
        check("k1_rst_value", 32'(b_timer_value), 32'd0);
        bcyc(1, 1, 5, 0, 0, 1);
        check("k1_load5", 32'(b_timer_value), 32'd5);
        bcyc(1, 1, 0, 0, 0, 1);
        check("k1_load0_value", 32'(b_timer_value), 32'd0);
        check("k1_load0_zero", 32'(b_zero), 32'd1);
        bcyc(1, 0, 0, 0, 0, 1);
        check("k1_zero_drop", 32'(b_zero), 32'd0);
        b_enable = 1; b_mode = 2'd0;
        #1;
        check("k1_tick", 32'(b_tick), 32'd1);
        bcyc(1, 0, 0, 0, 1, 0);
        check("k1_wrap_value", 32'(b_timer_value), 32'(MAX));
        check("k1_wrap_ovf", 32'(b_overflow), 32'd1);
        bcyc(1, 0, 0, 0, 1, 0);
        check("k1_step", 32'(b_timer_value), 32'(MAX - 1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
